// File: rtl/sync_fifo_param_if.sv
// rtl/sync_fifo_param_if.sv - producer/consumer handshake bundle for sync_fifo_param
interface sync_fifo_param_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH + 1);

   logic             push;
   logic [WIDTH-1:0] wdata;
   logic             full;
   logic             almost_full;
   logic             pop;
   logic [WIDTH-1:0] rdata;
   logic             empty;
   logic             almost_empty;
   logic [CW-1:0]    count;
   logic             overflow;
   logic             underflow;

   modport master (
      output push, wdata, pop,
      input  full, almost_full, rdata, empty, almost_empty, count, overflow, underflow
   );

   modport slave (
      input  push, wdata, pop,
      output full, almost_full, rdata, empty, almost_empty, count, overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised single-clock FWFT FIFO with thresholds and sticky error flags
module sync_fifo_param #(
   parameter int WIDTH         = 8,
   parameter int DEPTH         = 4,
   parameter int AFULL_THRESH  = 3,
   parameter int AEMPTY_THRESH = 1
) (
   input  logic             clk,
   input  logic             reset,
   sync_fifo_param_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wptr_q, wptr_d;
   logic [PW-1:0]    rptr_q, rptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;

   logic full, empty, pop_ok, push_ok;

   // Flags come only from the count register, so no push/pop reaches them combinationally.
   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign pop_ok  = bus.pop & ~empty;
   assign push_ok = bus.push & (~full | pop_ok);

   always_comb begin
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (push_ok) wptr_d = wptr_q + PW'(1);
      if (pop_ok)  rptr_d = rptr_q + PW'(1);
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      if (bus.push && !push_ok) overflow_d  = 1'b1;
      if (bus.pop && empty)     underflow_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage carries no reset; contents are meaningless while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push_ok && !reset) mem_q[wptr_q] <= bus.wdata;
   end

   assign bus.rdata        = mem_q[rptr_q];
   assign bus.full         = full;
   assign bus.empty        = empty;
   assign bus.almost_full  = (count_q >= CW'(AFULL_THRESH));
   assign bus.almost_empty = (count_q <= CW'(AEMPTY_THRESH));
   assign bus.count        = count_q;
   assign bus.overflow     = overflow_q;
   assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - directed self-checking bench for sync_fifo_param (WIDTH=8, DEPTH=4)
module tb_sync_fifo_param;
   logic clk;
   logic reset;
   int   n_checks;
   int   n_pass;

   sync_fifo_param_if #(.WIDTH(8), .DEPTH(4)) bus ();

   sync_fifo_param #(
      .WIDTH(8), .DEPTH(4), .AFULL_THRESH(3), .AEMPTY_THRESH(1)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, need $finish before 200000");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, need 0x%0h", tag, got, exp);
   endtask

   // Expected flags follow from the hand-computed occupancy.
   task automatic chk_state(input string tag, input int cnt);
      check({tag, ".count"}, 32'(bus.count), 32'(cnt));
      check({tag, ".empty"}, 32'(bus.empty), 32'(cnt == 0));
      check({tag, ".full"},  32'(bus.full),  32'(cnt == 4));
      check({tag, ".aempty"}, 32'(bus.almost_empty), 32'(cnt <= 1));
      check({tag, ".afull"},  32'(bus.almost_full),  32'(cnt >= 3));
   endtask

   task automatic cyc(input logic p, input logic q, input logic [7:0] d);
      bus.push  = p;
      bus.pop   = q;
      bus.wdata = d;
      @(posedge clk);
      #1;
      bus.push  = 1'b0;
      bus.pop   = 1'b0;
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00);
      reset = 1'b0;
   endtask

   initial begin
      n_checks  = 0;
      n_pass    = 0;
      reset     = 1'b1;
      bus.push  = 1'b0;
      bus.pop   = 1'b0;
      bus.wdata = 8'h00;
      @(posedge clk);
      #1;

      // 1 reset
      do_reset(2);
      chk_state("rst", 0);
      check("rst.ovf", 32'(bus.overflow), 0);
      check("rst.unf", 32'(bus.underflow), 0);

      // 2 fill / drain
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 1'b0, 8'(8'hA0 + i));
         chk_state($sformatf("fill%0d", i), i + 1);
      end
      check("fill.head", 32'(bus.rdata), 32'hA0);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("drain%0d.rdata", i), 32'(bus.rdata), 32'(8'hA0 + i));
         cyc(1'b0, 1'b1, 8'h00);
         check($sformatf("drain%0d.count", i), 32'(bus.count), 32'(3 - i));
      end
      chk_state("drained", 0);

      // 3 push+pop at full
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 8'(8'hA0 + i));
      chk_state("refill", 4);
      cyc(1'b1, 1'b1, 8'hB0);
      chk_state("pp_full", 4);
      check("pp_full.rdata", 32'(bus.rdata), 32'hA1);
      check("pp_full.ovf", 32'(bus.overflow), 0);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("pp_drain%0d", i), 32'(bus.rdata),
               (i == 3) ? 32'hB0 : 32'(8'hA1 + i));
         cyc(1'b0, 1'b1, 8'h00);
      end
      chk_state("pp_empty", 0);

      // 4 overflow
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 8'(8'hD0 + i));
      cyc(1'b1, 1'b0, 8'hCC);
      chk_state("ovf", 4);
      check("ovf.flag", 32'(bus.overflow), 1);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("ovf_drain%0d", i), 32'(bus.rdata), 32'(8'hD0 + i));
         cyc(1'b0, 1'b1, 8'h00);
      end
      chk_state("ovf_empty", 0);
      check("ovf.sticky", 32'(bus.overflow), 1);
      check("ovf.unf", 32'(bus.underflow), 0);

      // 5 underflow with push, then without
      do_reset(1);
      check("rst2.ovf", 32'(bus.overflow), 0);
      cyc(1'b1, 1'b1, 8'hE5);
      check("unf_push.flag", 32'(bus.underflow), 1);
      chk_state("unf_push", 1);
      check("unf_push.rdata", 32'(bus.rdata), 32'hE5);
      do_reset(1);
      check("rst3.unf", 32'(bus.underflow), 0);
      cyc(1'b0, 1'b1, 8'h00);
      check("unf_pop.flag", 32'(bus.underflow), 1);
      chk_state("unf_pop", 0);

      // 6 wrap then reset mid-operation
      do_reset(1);
      cyc(1'b1, 1'b0, 8'h10);
      cyc(1'b1, 1'b0, 8'h11);
      for (int i = 0; i < 10; i++) begin
         check($sformatf("wrap%0d.rdata", i), 32'(bus.rdata), 32'(8'h10 + i));
         cyc(1'b1, 1'b1, 8'(8'h12 + i));
         check($sformatf("wrap%0d.count", i), 32'(bus.count), 2);
      end
      check("wrap.head", 32'(bus.rdata), 32'h1A);
      do_reset(1);
      chk_state("midrst", 0);
      check("midrst.unf", 32'(bus.underflow), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
